// File: rtl/reg_load_arbiter.sv
// ----------------------------------------------------------------------------
// reg_load_arbiter
//
// Shares the load port of a single N-bit register between R requesters.
// A round-robin arbiter picks one requester, its data is captured into reg_d,
// pulsed into the register with a one-cycle reg_load, read back through reg_q
// on the following cycle, and the requester is then acknowledged. A readback
// that differs from the written value raises err alongside ack.
//
// Every grant walks IDLE -> LOAD -> CHECK -> IDLE, so at most one write
// completes every three cycles and arbitration never coincides with ack.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active low
//   req       per-requester level request, held until ack
//   req_data  requester i data at [i*N +: N]
//   ack       one-hot completion pulse (CHECK cycle)
//   err       readback mismatch, pulses together with ack
//   reg_d     data to the register D input, held until the next capture
//   reg_load  register load enable, one cycle per grant (LOAD cycle)
//   reg_q     register Q output, used for readback
//   busy      high during LOAD and CHECK
//   owner     index of the current or most recent grantee
// ----------------------------------------------------------------------------
module reg_load_arbiter #(
    parameter int N = 8,
    parameter int R = 4,
    localparam int W = $clog2(R)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] req_data,
    output logic [R-1:0]   ack,
    output logic           err,
    output logic [N-1:0]   reg_d,
    output logic           reg_load,
    input  logic [N-1:0]   reg_q,
    output logic           busy,
    output logic [W-1:0]   owner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   ptr;
    logic [W-1:0]   ptr_nxt;
    logic [W-1:0]   owner_nxt;
    logic [N-1:0]   reg_d_nxt;
    logic [W-1:0]   winner;
    logic [R-1:0]   owner_onehot;

    // Round-robin pick: the first requester at or after p+1 (mod R). The scan
    // runs from lowest to highest priority so the highest-priority hit is the
    // one left standing. Only indices below R can be produced.
    function automatic logic [W-1:0] rr_pick(input logic [W-1:0] p,
                                             input logic [R-1:0] r);
        logic [W-1:0] pick;
        int           idx;
        pick = '0;
        for (int k = R; k >= 1; k--) begin
            idx = (int'(p) + k) % R;
            if (r[idx]) begin
                pick = W'(idx);
            end
        end
        return pick;
    endfunction

    assign winner = rr_pick(ptr, req);

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first so
        // no path through the case leaves it unassigned (which would infer a latch).
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        reg_d_nxt = reg_d;
        unique case (state)
            S_IDLE: begin
                if (|req) begin
                    owner_nxt = winner;
                    reg_d_nxt = req_data[winner*N +: N];
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = S_CHECK;
            end
            S_CHECK: begin
                // The grantee becomes lowest priority for the next round.
                ptr_nxt   = owner;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            ptr   <= W'(R - 1);
            owner <= '0;
            reg_d <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            reg_d <= reg_d_nxt;
        end
    end

    // Outputs decode the state register directly, so an asynchronous reset
    // clears them at once and an aborted transaction never reaches ack.
    assign owner_onehot = R'(1) << owner;
    assign reg_load     = (state == S_LOAD);
    assign busy         = (state != S_IDLE);
    assign ack          = (state == S_CHECK) ? owner_onehot : '0;
    // reg_q only reflects the write once the LOAD edge has passed, so the
    // comparison is taken live during CHECK rather than captured earlier.
    assign err          = (state == S_CHECK) && (reg_q != reg_d);

endmodule

// File: tb/tb_reg_load_arbiter.sv
// ----------------------------------------------------------------------------
// tb_reg_load_arbiter
//
// Directed bench for reg_load_arbiter. A transaction-level model predicts the
// outputs for every cycle: an idle arbiter with pending requests grants the
// next requester after the last grantee and schedules the load, check and
// idle cycles that must follow. A compare process checks all outputs against
// that prediction on every falling edge; the directed sequences add literal
// expectations (grant order, ack spacing, err count, abort behaviour).
// ----------------------------------------------------------------------------
module tb_reg_load_arbiter;

    localparam int N = 8;
    localparam int R = 4;
    localparam int W = 2;

    logic           clk      = 1'b0;
    logic           rst      = 1'b1;
    logic [R-1:0]   req      = '0;
    logic [R*N-1:0] req_data = '0;
    logic [R-1:0]   ack;
    logic           err;
    logic [N-1:0]   reg_d;
    logic           reg_load;
    logic [N-1:0]   reg_q;
    logic           busy;
    logic [W-1:0]   owner;

    // Bench-side target register, with an optional readback fault on 8'h3C.
    logic [N-1:0]   reg_store = '0;
    logic           fault_en  = 1'b0;

    int             n_tests = 0;
    int             n_fail  = 0;
    int             cyc     = 0;
    bit             cmp_en  = 1'b0;

    logic [R-1:0]   ack_log[$];
    int             ack_cyc[$];
    int             err_cnt = 0;

    always #5 clk = ~clk;

    reg_load_arbiter #(.N(N), .R(R)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .err      (err),
        .reg_d    (reg_d),
        .reg_load (reg_load),
        .reg_q    (reg_q),
        .busy     (busy),
        .owner    (owner)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reg_load) reg_store <= reg_d;
    end

    assign reg_q = (fault_en && reg_store == 8'h3C) ? '0 : reg_store;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic         load;
        logic         busy;
        logic         chk;
        logic [R-1:0] ack;
        logic [W-1:0] owner;
        logic [N-1:0] d;
    } exp_t;

    exp_t         cur = '0;
    exp_t         sched[$];
    int           m_ptr   = R - 1;
    int           m_owner = 0;
    logic [N-1:0] m_d     = '0;
    int           mg;

    function automatic exp_t mk(input logic ld, input logic bz, input logic ck,
                                input logic [R-1:0] a, input logic [W-1:0] o,
                                input logic [N-1:0] d);
        exp_t e;
        e.load  = ld;
        e.busy  = bz;
        e.chk   = ck;
        e.ack   = a;
        e.owner = o;
        e.d     = d;
        return e;
    endfunction

    // Next requester after 'last', going round the ring; -1 if none.
    function automatic int grant_of(input int last, input logic [R-1:0] r);
        int cand;
        cand = last;
        repeat (R) begin
            cand = (cand + 1) % R;
            if (r[cand]) return cand;
        end
        return -1;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            sched.delete();
            m_ptr   = R - 1;
            m_owner = 0;
            m_d     = '0;
            cur     = '0;
        end else if (sched.size() != 0) begin
            cur = sched.pop_front();
        end else begin
            mg = grant_of(m_ptr, req);
            if (mg < 0) begin
                cur = mk(1'b0, 1'b0, 1'b0, '0, W'(m_owner), m_d);
            end else begin
                m_owner = mg;
                m_ptr   = mg;
                m_d     = req_data[mg*N +: N];
                cur     = mk(1'b1, 1'b1, 1'b0, '0, W'(mg), m_d);
                sched.push_back(mk(1'b0, 1'b1, 1'b1, R'(1) << mg, W'(mg), m_d));
                sched.push_back(mk(1'b0, 1'b0, 1'b0, '0, W'(mg), m_d));
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("cmp_reg_load", reg_load, cur.load);
            check("cmp_busy",     busy,     cur.busy);
            check("cmp_ack",      ack,      cur.ack);
            check("cmp_err",      err,      cur.chk && fault_en && (cur.d == 8'h3C));
            check("cmp_owner",    owner,    cur.owner);
            check("cmp_reg_d",    reg_d,    cur.d);
        end
    end

    // Ack/err event log for the directed sequences.
    initial forever begin
        @(negedge clk);
        if (rst && ack != '0) begin
            ack_log.push_back(ack);
            ack_cyc.push_back(cyc);
            if (err) err_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_load(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (reg_load) ok = 1'b1;
        end
        check("load_seen", ok, 1'b1);
    endtask

    task automatic wait_acks(input int n);
        int i;
        i = 0;
        while (ack_log.size() < n && i < 60) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("ack_count_reached", ack_log.size(), n);
    endtask

    logic [R-1:0] exp_rr[5]   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [R-1:0] exp_fair[4] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit ok;
        #1 rst = 1'b0;
        cmp_en = 1'b1;

        // 1: reset held with all requesting, then first grant goes to 0.
        req      = 4'b1111;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t1_rst_reg_load", reg_load, 1'b0);
        check("t1_rst_busy",     busy,     1'b0);
        check("t1_rst_ack",      ack,      4'b0000);
        check("t1_rst_err",      err,      1'b0);
        check("t1_rst_owner",    owner,    2'd0);
        check("t1_rst_reg_d",    reg_d,    8'h00);
        ack_log.delete();
        ack_cyc.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        wait_load(ok);
        check("t1_first_owner", owner, 2'd0);
        check("t1_first_data",  reg_d, 8'h11);
        wait_acks(1);
        check("t1_first_ack", ack_log[0], 4'b0001);
        @(posedge clk);
        #1 req = '0;
        idle(3);

        // 2: single write, exact latency.
        req_data = '0;
        req_data[2*N +: N] = 8'hA5;
        req = 4'b0100;
        @(negedge clk);
        check("t2_idle_load", reg_load, 1'b0);
        @(negedge clk);
        check("t2_load",       reg_load, 1'b1);
        check("t2_load_data",  reg_d,    8'hA5);
        check("t2_load_owner", owner,    2'd2);
        @(negedge clk);
        check("t2_ack",      ack,      4'b0100);
        check("t2_err",      err,      1'b0);
        check("t2_load_off", reg_load, 1'b0);
        @(posedge clk);
        #1 req = '0;
        idle(3);

        // 3: round robin from reset, acks 3 cycles apart.
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        ack_log.delete();
        ack_cyc.delete();
        req_data = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        req = 4'b1111;
        wait_acks(5);
        @(posedge clk);
        #1 req = '0;
        idle(3);
        for (int i = 0; i < 5; i++) begin
            check("t3_rr_ack", ack_log[i], exp_rr[i]);
            if (i > 0) check("t3_rr_gap", ack_cyc[i] - ack_cyc[i-1], 3);
        end

        // 4: fairness between two requesters.
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        ack_log.delete();
        ack_cyc.delete();
        req = 4'b1001;
        wait_acks(4);
        @(posedge clk);
        #1 req = '0;
        idle(3);
        for (int i = 0; i < 4; i++) begin
            check("t4_fair_ack", ack_log[i], exp_fair[i]);
        end

        // 5: readback fault on 8'h3C only.
        ack_log.delete();
        ack_cyc.delete();
        err_cnt  = 0;
        fault_en = 1'b1;
        req_data = '0;
        req_data[0*N +: N] = 8'h3C;
        req_data[1*N +: N] = 8'h5A;
        req = 4'b0011;
        wait_acks(2);
        @(posedge clk);
        #1 req = '0;
        idle(2);
        fault_en = 1'b0;
        check("t5_err_count", err_cnt,    1);
        check("t5_ack0",      ack_log[0], 4'b0001);
        check("t5_ack1",      ack_log[1], 4'b0010);
        idle(2);

        // 6: reset during LOAD aborts; pending request re-arbitrated from R-1.
        ack_log.delete();
        ack_cyc.delete();
        req_data = '0;
        req_data[3*N +: N] = 8'h99;
        req_data[1*N +: N] = 8'h77;
        req = 4'b1010;
        wait_load(ok);
        check("t6_pre_owner", owner, 2'd3);
        check("t6_pre_data",  reg_d, 8'h99);
        #1 rst = 1'b0;
        #1;
        check("t6_abort_load",  reg_load, 1'b0);
        check("t6_abort_busy",  busy,     1'b0);
        check("t6_abort_owner", owner,    2'd0);
        check("t6_abort_reg_d", reg_d,    8'h00);
        idle(2);
        rst = 1'b1;
        wait_acks(1);
        check("t6_regrant_ack", ack_log[0], 4'b0010);
        @(posedge clk);
        #1 req = '0;
        idle(4);
        check("t6_single_ack", ack_log.size(), 1);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
